sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl_if.sv | 30 +++
 rtl/sync_fifo_ctrl.sv | 85 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake and status bundle for sync_fifo_ctrl.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  logic                     wr_enb;
  logic [DATA_W-1:0]        wr_data;
  logic                     rd_enb;
  logic [DATA_W-1:0]        rd_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_almost_full;
  logic                     fifo_almost_empty;
  logic                     fifo_overrun;
  logic                     fifo_underrun;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output wr_enb, wr_data, rd_enb,
    input  rd_data, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
           fifo_overrun, fifo_underrun, fifo_count
  );

  modport slave (
    input  wr_enb, wr_data, rd_enb,
    output rd_data, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
           fifo_overrun, fifo_underrun, fifo_count
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with registered read data, occupancy thresholds and overrun/underrun flags.
// Defining FIFO_STICKY_ERR_EN holds the error flags high once set, until the next reset.
module sync_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_CNT   = (AW + 1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] rd_q;
  logic              ovr_q;
  logic              unf_q;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovr_evt;
  logic              unf_evt;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
  assign rd_acc  = fifo.rd_enb && !empty;
  assign wr_acc  = fifo.wr_enb && (!full || rd_acc);
  assign ovr_evt = fifo.wr_enb && !wr_acc;
  assign unf_evt = fifo.rd_enb && empty;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr[AW-1:0]] <= fifo.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
      ovr_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_q   <= mem[rd_ptr[AW-1:0]];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
`ifdef FIFO_STICKY_ERR_EN
      ovr_q <= ovr_q | ovr_evt;
      unf_q <= unf_q | unf_evt;
`else
      ovr_q <= ovr_evt;
      unf_q <= unf_evt;
`endif
    end
  end

  assign fifo.rd_data           = rd_q;
  assign fifo.fifo_count        = count;
  assign fifo.fifo_full         = full;
  assign fifo.fifo_empty        = empty;
  assign fifo.fifo_almost_full  = (count >= AF_CNT);
  assign fifo.fifo_almost_empty = (count <= AE_CNT);
  assign fifo.fifo_overrun      = ovr_q;
  assign fifo.fifo_underrun     = unf_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a queue model of the FIFO contents feeds a
// scoreboard of expected read words, and all status outputs are compared every cycle.
module tb_sync_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo_bus ();

  sync_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (fifo_bus.slave)
  );

  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_rd;
  logic              exp_ovr;
  logic              exp_unf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkState(input string tag);
    int n;
    n = model_q.size();
    checkOutput({tag, " count"},        32'(fifo_bus.fifo_count), 32'(n));
    checkOutput({tag, " full"},         32'(fifo_bus.fifo_full), 32'(n == DEPTH));
    checkOutput({tag, " empty"},        32'(fifo_bus.fifo_empty), 32'(n == 0));
    checkOutput({tag, " almost_full"},  32'(fifo_bus.fifo_almost_full), 32'(n >= DEPTH - 1));
    checkOutput({tag, " almost_empty"}, 32'(fifo_bus.fifo_almost_empty), 32'(n <= 1));
    checkOutput({tag, " overrun"},      32'(fifo_bus.fifo_overrun), 32'(exp_ovr));
    checkOutput({tag, " underrun"},     32'(fifo_bus.fifo_underrun), 32'(exp_unf));
    checkOutput({tag, " rd_data"},      32'(fifo_bus.rd_data), 32'(exp_rd));
  endtask

  // One clock of stimulus: model is updated from pre-edge occupancy, outputs checked #1 after the edge.
  task automatic applyStimulus(input string tag, input logic wr, input logic [DATA_W-1:0] d,
                               input logic rd);
    bit rd_ok;
    bit wr_ok;
    bit ovr_evt;
    bit unf_evt;
    @(negedge clk);
    fifo_bus.wr_enb  = wr;
    fifo_bus.wr_data = d;
    fifo_bus.rd_enb  = rd;
    rd_ok   = rd && (model_q.size() != 0);
    wr_ok   = wr && ((model_q.size() < DEPTH) || rd_ok);
    ovr_evt = wr && !wr_ok;
    unf_evt = rd && (model_q.size() == 0);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
    exp_ovr = exp_ovr | ovr_evt;
    exp_unf = exp_unf | unf_evt;
`else
    exp_ovr = ovr_evt;
    exp_unf = unf_evt;
`endif
    @(posedge clk);
    #1;
    fifo_bus.wr_enb = 1'b0;
    fifo_bus.rd_enb = 1'b0;
    if (rd_ok) exp_rd = exp_q.pop_front();
    checkState(tag);
  endtask

  // Requests are held high across the reset edge to show that reset wins.
  task automatic applyReset(input string tag);
    @(negedge clk);
    rst              = 1'b1;
    fifo_bus.wr_enb  = 1'b1;
    fifo_bus.rd_enb  = 1'b1;
    fifo_bus.wr_data = 8'hEE;
    @(posedge clk);
    #1;
    rst             = 1'b0;
    fifo_bus.wr_enb = 1'b0;
    fifo_bus.rd_enb = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_rd  = '0;
    exp_ovr = 1'b0;
    exp_unf = 1'b0;
    checkState(tag);
  endtask

  initial begin
    logic [DATA_W-1:0] pat[4];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    fifo_bus.wr_enb  = 1'b0;
    fifo_bus.rd_enb  = 1'b0;
    fifo_bus.wr_data = '0;
    exp_rd  = '0;
    exp_ovr = 1'b0;
    exp_unf = 1'b0;

    applyReset("reset");

    applyStimulus("single_wr", 1'b1, 8'hA5, 1'b0);
    applyStimulus("single_rd", 1'b0, 8'h00, 1'b1);
    applyStimulus("single_idle", 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus("seq4_wr", 1'b1, pat[i], 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("seq4_rd", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < DEPTH; i++) applyStimulus("fill_wr", 1'b1, 8'(8'h10 + i), 1'b0);
    applyStimulus("overrun_wr", 1'b1, 8'hFF, 1'b0);
    applyStimulus("overrun_idle", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain_rd", 1'b0, 8'h00, 1'b1);
    applyStimulus("underrun_rd", 1'b0, 8'h00, 1'b1);
    applyStimulus("underrun_idle", 1'b0, 8'h00, 1'b0);

    applyReset("reset2");
    for (int i = 0; i < DEPTH; i++) applyStimulus("refill_wr", 1'b1, 8'(8'h10 + i), 1'b0);
    applyStimulus("full_wr_rd", 1'b1, 8'h99, 1'b1);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain99_rd", 1'b0, 8'h00, 1'b1);

    applyStimulus("empty_wr_rd", 1'b1, 8'h5A, 1'b1);
    applyStimulus("empty_wr_rd_rd", 1'b0, 8'h00, 1'b1);

    applyReset("reset3");
    for (int i = 0; i < 5; i++) applyStimulus("mid_wr", 1'b1, 8'(8'h60 + i), 1'b0);
    applyReset("mid_reset");
    applyStimulus("post_reset_wr", 1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus("wrap_wr_rd", 1'b1, 8'(8'h40 + i), 1'b1);
    applyStimulus("wrap_last_rd", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 60; i++)
      applyStimulus("random", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
